// File: rtl/detector_pkg.sv
// rtl/detector_pkg.sv - shared state type and default parameters for the detector sequencing controller.
package detector_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RST,
    SHIFT,
    DRAIN,
    REPORT
  } state_t;

  localparam int DET_W_DEF     = 8;
  localparam int DET_Z_LAT_DEF = 1;

endpackage

// File: rtl/detector_serializer.sv
// rtl/detector_serializer.sv - W-bit load/shift-left register, MSB first, with bit index and last-bit flag.
module detector_serializer
  import detector_pkg::*;
#(
  parameter int W = DET_W_DEF,
  localparam int KW = (W > 1) ? $clog2(W) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  input  logic          i_shift,
  input  logic [W-1:0]  i_data,
  output logic          o_msb,
  output logic [KW-1:0] o_idx,
  output logic          o_last
);

  logic [W-1:0]  r_sr;
  logic [KW-1:0] r_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sr  <= '0;
      r_idx <= '0;
    end else if (i_load) begin
      r_sr  <= i_data;
      r_idx <= '0;
    end else if (i_shift) begin
      r_sr  <= {r_sr[W-2:0], 1'b0};
      r_idx <= o_last ? '0 : r_idx + KW'(1);
    end
  end

  assign o_msb  = r_sr[W-1];
  assign o_idx  = r_idx;
  assign o_last = (r_idx == KW'(W - 1));

endmodule

// File: rtl/detector_ctrl.sv
// rtl/detector_ctrl.sv - word-to-serial sequencer and match counter around a bit-serial sequence detector.
// Optional per-word detector reset: DETECTOR_CTRL_WORD_ISOLATE_EN.
module detector_ctrl
  import detector_pkg::*;
#(
  parameter int W     = DET_W_DEF,
  parameter int Z_LAT = DET_Z_LAT_DEF,
  parameter int CW    = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [W-1:0]  s_data,
  output logic          det_reset,
  output logic          det_w,
  input  logic          det_z,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [CW-1:0] m_count,
  output logic          m_hit
);

  localparam int KW = $clog2(W);
  localparam logic [2:0] DRAIN_LAST = 3'((Z_LAT > 0) ? Z_LAT - 1 : 0);

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_count;
  logic [2:0]    r_drain_cnt;
  logic          w_load;
  logic          w_shift;
  logic          w_msb;
  logic          w_last;
  logic [KW-1:0] w_idx;
  logic          w_in_window;
  logic          w_s_fire;
  logic          w_m_fire;

  assign w_s_fire = s_valid & s_ready;
  assign w_m_fire = m_valid & m_ready;

  detector_serializer #(.W(W)) u_ser (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (s_data),
    .o_msb   (w_msb),
    .o_idx   (w_idx),
    .o_last  (w_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_s_fire) begin
`ifdef DETECTOR_CTRL_WORD_ISOLATE_EN
          w_next = RST;
`else
          w_next = SHIFT;
`endif
        end
      end
      RST:     w_next = SHIFT;
      SHIFT:   if (w_last) w_next = (Z_LAT == 0) ? REPORT : DRAIN;
      DRAIN:   if (r_drain_cnt == DRAIN_LAST) w_next = REPORT;
      REPORT:  if (w_m_fire) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The counting window trails the shifted bits by the detector latency: the
  // tail of SHIFT from index Z_LAT onward plus all of DRAIN.
  always_comb begin
    s_ready     = 1'b0;
    m_valid     = 1'b0;
    det_w       = 1'b0;
    det_reset   = reset;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_in_window = 1'b0;
    case (r_state)
      IDLE: begin
        s_ready = 1'b1;
        w_load  = s_valid;
      end
`ifdef DETECTOR_CTRL_WORD_ISOLATE_EN
      RST: det_reset = 1'b1;
`endif
      SHIFT: begin
        det_w       = w_msb;
        w_shift     = 1'b1;
        w_in_window = (int'(w_idx) >= Z_LAT);
      end
      DRAIN:   w_in_window = 1'b1;
      REPORT:  m_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count     <= '0;
      r_drain_cnt <= '0;
    end else begin
      if (w_s_fire) begin
        r_count <= '0;
      end else if (w_in_window && det_z) begin
        r_count <= r_count + CW'(1);
      end
      if (r_state == DRAIN) begin
        r_drain_cnt <= r_drain_cnt + 3'd1;
      end else begin
        r_drain_cnt <= '0;
      end
    end
  end

  assign m_count = r_count;
  assign m_hit   = |r_count;

endmodule
